i2s_master: RTL

Clock-master I2S port: generates `sclk` and `lrclk` from the system clock, serializes a stereo sample pair per frame on `sdo`, and deserializes `sdi` into a stereo pair. It is the counterpart to our slave-side `i2s` block. It drives codecs and peripherals that expect the FPGA to own the bit and word clocks.

---
 rtl/i2s_master.sv | 110 +++++++++++
 1 files changed

// File: rtl/i2s_master.sv
// i2s_master: clock-master Philips I2S port; define I2S_MASTER_HOLD_EN to resend the last pair on underrun
module i2s_master #(
  parameter int DW = 24,
  parameter int FRAME_BITS = 32,
  parameter int SCLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] tx_ldata,
  input  logic [DW-1:0] tx_rdata,
  output logic          tx_rd_en,
  input  logic          tx_rd_valid,
  output logic [DW-1:0] rx_ldata,
  output logic [DW-1:0] rx_rdata,
  output logic          rx_valid,
  output logic          sclk,
  output logic          lrclk,
  output logic          sdo,
  input  logic          sdi
);
`ifdef I2S_MASTER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int DV = $clog2(2 * SCLK_DIV);
  localparam int KW = $clog2(2 * FRAME_BITS);
  localparam logic [DV-1:0] D_LAST = DV'(2 * SCLK_DIV - 1);
  localparam logic [DV-1:0] D_SAMP = DV'(SCLK_DIV - 1);
  localparam logic [DV-1:0] D_RISE = DV'(SCLK_DIV);
  localparam logic [KW-1:0] K_LAST = KW'(2 * FRAME_BITS - 1);
  localparam logic [KW-1:0] K_HALF = KW'(FRAME_BITS);
  localparam logic [KW-1:0] K_DW = KW'(DW);
  localparam logic [KW-1:0] K_L0 = KW'(1);
  localparam logic [KW-1:0] K_R0 = KW'(FRAME_BITS + 1);

  logic [DV-1:0] div;
  logic [KW-1:0] k, k_inc;
  logic slot_end, take, clr, cap_l, cap_r, got, primed;
  logic [DW-1:0] tx_l, tx_r, l_nxt, r_nxt, sh, lrx, rrx;

  assign tx_rd_en = rst && k == '0 && div == '0;

  // slot bookkeeping, tx pair selection and which channel (if any) this slot receives
  always_comb begin
    slot_end = div == D_LAST;
    k_inc = k == K_LAST ? '0 : k + 1'b1;
    take = k == '0 && tx_rd_valid && !got;
    clr = !HOLD && k == '0 && div == '0;
    l_nxt = take ? tx_ldata : clr ? '0 : tx_l;
    r_nxt = take ? tx_rdata : clr ? '0 : tx_r;
    cap_l = k != '0 && k <= K_DW;
    cap_r = k > K_HALF ? k - K_HALF <= K_DW : k == '0 && DW == FRAME_BITS;
  end

  // free-running divider and slot counter with registered bit and word clocks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      k <= '0;
      sclk <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      div <= slot_end ? '0 : div + 1'b1;
      sclk <= div == D_SAMP ? 1'b1 : slot_end ? 1'b0 : sclk;
      k <= slot_end ? k_inc : k;
      lrclk <= slot_end ? k_inc >= K_HALF : lrclk;
    end
  end

  // accept one pair per slot 0, then shift each channel out MSB first from the slot after lrclk moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      got <= 1'b0;
      tx_l <= '0;
      tx_r <= '0;
      sh <= '0;
      sdo <= 1'b0;
    end else begin
      got <= k == '0 && (got || tx_rd_valid);
      tx_l <= l_nxt;
      tx_r <= r_nxt;
      if (slot_end) begin
        sh <= k_inc == K_L0 ? l_nxt << 1 : k_inc == K_R0 ? r_nxt << 1 : sh << 1;
        sdo <= k_inc == K_L0 ? l_nxt[DW-1] : k_inc == K_R0 ? r_nxt[DW-1] : sh[DW-1];
      end
    end
  end

  // sample sdi as sclk rises and publish the pair one clk after the slot-0 rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lrx <= '0;
      rrx <= '0;
      primed <= 1'b0;
      rx_valid <= 1'b0;
      rx_ldata <= '0;
      rx_rdata <= '0;
    end else begin
      if (div == D_SAMP && cap_l) lrx <= {lrx[DW-2:0], sdi};
      if (div == D_SAMP && cap_r) rrx <= {rrx[DW-2:0], sdi};
      if (k == K_HALF) primed <= 1'b1;
      rx_valid <= div == D_RISE && k == '0 && primed;
      if (div == D_RISE && k == '0 && primed) begin
        rx_ldata <= lrx;
        rx_rdata <= rrx;
      end
    end
  end
endmodule
